// File: rtl/servant_uart_tx.sv
// servant_uart_tx: Wishbone-attached UART transmitter with a small TX FIFO.
// Register map: adr 0 = DATA (write pushes a byte, read returns 0),
//               adr 1 = STATUS {28'b0, overflow, busy, empty, full}.
// Optional feature: define SERVANT_UART_TX_PARITY_EN to insert an even
// parity bit between the data bits and the stop bit (11-bit frames).
//
// state  | meaning
// IDLE   | line high, waiting for a byte in the FIFO
// START  | driving the start bit (0)
// DATA   | driving data bits LSB first, idx_q selects the bit
// PARITY | driving even parity of the byte (parity build only)
// STOP   | driving the stop bit (1), then back to IDLE
module servant_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_uart_tx,
    output logic        o_tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERVANT_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    byte_q;
    logic          tx_q;
    logic          ack_q;
    logic [31:0]   rdt_q;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic accept, data_wr, stat_rd, push, pop, ovf_set;
    logic fifo_full, fifo_empty, busy;

    // Upper data bits and upper byte enables have no function here.
    logic unused_bits;
    assign unused_bits = ^{i_wb_dat[31:8], i_wb_sel[3:1]};

    assign accept     = i_wb_cyc & ~ack_q;
    assign data_wr    = accept & i_wb_we & ~i_wb_adr & i_wb_sel[0];
    assign stat_rd    = accept & ~i_wb_we & i_wb_adr;
    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_empty = (count_q == '0);
    // Fullness is judged before any same-edge pop, so a write into a full
    // FIFO is always dropped.
    assign push       = data_wr & ~fifo_full;
    assign ovf_set    = data_wr & fifo_full;
    assign pop        = (state_q == IDLE) & ~fifo_empty;
    assign busy       = (state_q != IDLE) | ~fifo_empty;

    // Next FIFO occupancy and sticky overflow (a new overflow beats the clear).
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (ovf_set)      ovf_d = 1'b1;
        else if (stat_rd) ovf_d = 1'b0;
    end

    // Bus handshake, read data, FIFO pointers and overflow flag.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            ack_q    <= 1'b0;
            rdt_q    <= 32'h0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ack_q <= accept;
            if (accept)
                rdt_q <= stat_rd ? {28'b0, ovf_q, busy, fifo_empty, fifo_full} : 32'h0;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_wb_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_wb_dat[7:0];
    end

    // Transmit FSM with registered serial output.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            byte_q  <= 8'h0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        byte_q  <= mem_q[rd_ptr_q];
                        state_q <= START;
                        tx_q    <= 1'b0;
                        cnt_q   <= BIT_RELOAD;
                        idx_q   <= 3'd0;
                    end
                end
                START: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= DATA;
                        tx_q    <= byte_q[0];
                        idx_q   <= 3'd0;
                        cnt_q   <= BIT_RELOAD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= BIT_RELOAD;
                        if (idx_q == 3'd7) begin
`ifdef SERVANT_UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= ^byte_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= byte_q[idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
`ifdef SERVANT_UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                        cnt_q   <= BIT_RELOAD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
`endif
                STOP: begin
                    tx_q <= 1'b1;
                    if (cnt_q == 16'd0) state_q <= IDLE;
                    else                cnt_q   <= cnt_q - 16'd1;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign o_wb_ack  = ack_q;
    assign o_wb_rdt  = rdt_q;
    assign o_uart_tx = tx_q;
    assign o_tx_busy = busy;

endmodule

// File: tb/tb_servant_uart_tx.sv
// Directed bench for servant_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Frame expectations follow SERVANT_UART_TX_PARITY_EN when it is defined.
module tb_servant_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef SERVANT_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic        clk;
    logic        rst_n;
    logic        adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    servant_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_wb_adr   (adr),
        .i_wb_dat   (dat),
        .i_wb_sel   (sel),
        .i_wb_we    (we),
        .i_wb_cyc   (cyc),
        .o_wb_rdt   (rdt),
        .o_wb_ack   (ack),
        .o_uart_tx  (tx),
        .o_tx_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef SERVANT_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wb_access(input logic a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] r);
        logic seen;
        seen = 1'b0;
        adr = a; we = w; dat = d; sel = s; cyc = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            if (ack) begin
                seen = 1'b1;
                break;
            end
        end
        check("wb_ack", 32'(seen), 32'd1);
        r = rdt;
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] b);
        logic [31:0] r;
        wb_access(1'b0, 1'b1, {24'hABCDEF, b}, 4'h1, r);
    endtask

    task automatic wb_read(input logic a, output logic [31:0] r);
        wb_access(a, 1'b0, 32'h0, 4'hF, r);
    endtask

    // Compares the line every cycle from frame cycle 'skip' to the end of the stop bit.
    task automatic check_frame(input logic [7:0] b, input int skip, input string tag);
        for (int k = skip; k < FRAME_CYC; k++) begin
            check(tag, 32'(tx), 32'(frame_bit(b, k / CPB)));
            step();
        end
    endtask

    // Mid-bit sampling receiver.
    task automatic rx_byte(output logic [7:0] d);
        logic found;
        found = 1'b0;
        d = 8'h0;
        for (int n = 0; n < 400; n++) begin
            if (tx == 1'b0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("rx_start", 32'(found), 32'd1);
        if (found) begin
            repeat (2) step();
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) step();
                d[i] = tx;
            end
`ifdef SERVANT_UART_TX_PARITY_EN
            repeat (CPB) step();
            check("rx_parity", 32'(tx), 32'(^d));
`endif
            repeat (CPB) step();
            check("rx_stop", 32'(tx), 32'd1);
        end
    endtask

    logic [31:0] r;

    initial begin
        rst_n = 1'b0; cyc = 1'b0; we = 1'b0; adr = 1'b0; dat = 32'h0; sel = 4'h0;
        #12;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdt", rdt, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        cyc = 1'b1;
        step();
        check("rst_ack_cyc", 32'(ack), 32'd0);
        cyc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // STATUS read with cyc held: ack toggles, one ack per access.
        @(negedge clk);
        adr = 1'b1; we = 1'b0; cyc = 1'b1;
        check("hold_ack0", 32'(ack), 32'd0);
        step();
        check("hold_ack1", 32'(ack), 32'd1);
        check("idle_status", rdt, 32'h2);
        step();
        check("hold_ack_gap", 32'(ack), 32'd0);
        step();
        check("hold_ack2", 32'(ack), 32'd1);
        cyc = 1'b0;
        step();
        check("hold_ack_end", 32'(ack), 32'd0);

        // DATA read returns zero; STATUS writes and sel[0]=0 writes are ignored.
        wb_read(1'b0, r);
        check("data_read", r, 32'h0);
        wb_access(1'b1, 1'b1, 32'hFF, 4'hF, r);
        wb_access(1'b0, 1'b1, 32'h5A, 4'h2, r);
        repeat (3) step();
        check("ignored_wr_busy", 32'(busy), 32'd0);
        wb_read(1'b1, r);
        check("ignored_wr_status", r, 32'h2);

        // Single byte 0x55: start bit appears the edge after the accepting edge.
        wb_write(8'h55);
        check("tx_after_accept", 32'(tx), 32'd1);
        check("busy_after_accept", 32'(busy), 32'd1);
        step();
        check_frame(8'h55, 0, "frame_55");
        check("idle_tx_55", 32'(tx), 32'd1);
        check("busy_fall_55", 32'(busy), 32'd0);

        // 0xA5 exercises parity 0 in the parity build.
        wb_write(8'hA5);
        step();
        check_frame(8'hA5, 0, "frame_A5");
        check("busy_fall_A5", 32'(busy), 32'd0);

        // Back-to-back frames: exactly one idle cycle between stop and start.
        wb_write(8'h00);
        wb_write(8'hFF);
        check_frame(8'h00, 1, "frame_00");
        check("gap_tx", 32'(tx), 32'd1);
        check("gap_busy", 32'(busy), 32'd1);
        step();
        check_frame(8'hFF, 0, "frame_FF");
        check("busy_fall_FF", 32'(busy), 32'd0);

        // Six writes during transmission: five sent, sixth dropped with overflow.
        fork
            begin
                for (int i = 1; i <= 6; i++) wb_write(8'(8'h11 * i));
                wb_read(1'b1, r);
                check("status_ovf", r, 32'h0D);
                wb_read(1'b1, r);
                check("status_ovf_clr", r, 32'h05);
            end
            begin
                logic [7:0] d;
                for (int i = 1; i <= 5; i++) begin
                    rx_byte(d);
                    check("rx_data", 32'(d), 32'(8'(8'h11 * i)));
                end
                for (int n = 0; n < 10; n++) begin
                    if (!busy) break;
                    step();
                end
                check("drained_busy", 32'(busy), 32'd0);
            end
        join
        wb_read(1'b1, r);
        check("status_drained", r, 32'h2);

        // Reset in the middle of data bit 3 abandons the frame and the FIFO.
        wb_write(8'h00);
        wb_write(8'h00);
        repeat (16) step();
        check("pre_reset_tx", 32'(tx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_tx", 32'(tx), 32'd1);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_ack", 32'(ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();
        check("post_reset_tx", 32'(tx), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);
        wb_read(1'b1, r);
        check("post_reset_status", r, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
